// File: rtl/roce_fault_pkg.sv
// roce_fault_pkg: mode encodings, FSM states and the LFSR polynomial shared by the
// RoCE fault injectors.
package roce_fault_pkg;

    localparam logic [1:0] FAULT_MODE_PASS   = 2'd0;
    localparam logic [1:0] FAULT_MODE_RANDOM = 2'd1;
    localparam logic [1:0] FAULT_MODE_NTH    = 2'd2;
    localparam logic [1:0] FAULT_MODE_BURST  = 2'd3;

    // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
    localparam logic [31:0] FAULT_LFSR_POLY = 32'h80200003;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_MARK,
        ST_DROP
    } fault_state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ FAULT_LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/roce_fault_lfsr.sv
// roce_fault_lfsr: 32-bit Galois PRNG that steps once per advance pulse and
// restarts from SEED on reset, so fault sequences are reproducible.
module roce_fault_lfsr
    import roce_fault_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE12345
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv_i,
    output logic [31:0] state_o
);

    logic [31:0] lfsr_q, lfsr_d;

    always_comb lfsr_d = adv_i ? lfsr_step(lfsr_q) : lfsr_q;

    always_ff @(posedge clk) begin
        lfsr_q <= rst ? SEED : lfsr_d;
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/roce_fault_injector.sv
// roce_fault_injector: RoCE TX fault source between header/payload generator and UDP/IP
// stack; marks or discards whole frames. Statistics built only with ROCE_FAULT_STATS_EN.
module roce_fault_injector
    import roce_fault_pkg::*;
#(
    parameter int          DATA_WIDTH = 64,
    parameter int          HDR_WIDTH  = 560,
    parameter logic [31:0] LFSR_SEED  = 32'hACE12345,
    parameter int          CNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              cfg_mode,
    input  logic                    cfg_action,
    input  logic [31:0]             cfg_threshold,
    input  logic [15:0]             cfg_period,
    input  logic [7:0]              cfg_burst_len,
    input  logic                    s_hdr_valid,
    output logic                    s_hdr_ready,
    input  logic [HDR_WIDTH-1:0]    s_hdr_data,
    output logic                    m_hdr_valid,
    input  logic                    m_hdr_ready,
    output logic [HDR_WIDTH-1:0]    m_hdr_data,
    input  logic [DATA_WIDTH-1:0]   s_payload_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_payload_axis_tkeep,
    input  logic                    s_payload_axis_tvalid,
    output logic                    s_payload_axis_tready,
    input  logic                    s_payload_axis_tlast,
    input  logic                    s_payload_axis_tuser,
    output logic [DATA_WIDTH-1:0]   m_payload_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_payload_axis_tkeep,
    output logic                    m_payload_axis_tvalid,
    input  logic                    m_payload_axis_tready,
    output logic                    m_payload_axis_tlast,
    output logic                    m_payload_axis_tuser,
    output logic [CNT_WIDTH-1:0]    stat_frames,
    output logic [CNT_WIDTH-1:0]    stat_faults
);

    fault_state_t state_q, state_d;
    logic [15:0]  nth_q, nth_d;
    logic [7:0]   burst_q, burst_d;
    logic [31:0]  lfsr;
    logic         rnd, hit, drop, fwd, hdr_hs, last_hs;

    roce_fault_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .adv_i   (hdr_hs),
        .state_o (lfsr)
    );

    // Fault decision, meaningful only while IDLE waiting for a header
    always_comb begin
        rnd  = lfsr < cfg_threshold;
        hit  = (cfg_mode == FAULT_MODE_RANDOM) ? rnd :
               (cfg_mode == FAULT_MODE_NTH)    ? (cfg_period != 16'd0 && nth_q == cfg_period - 16'd1) :
               (cfg_mode == FAULT_MODE_BURST)  ? (burst_q != 8'd0 || rnd) : 1'b0;
        drop = hit && cfg_action;
    end

    always_comb begin
        nth_d   = !hdr_hs ? nth_q :
                  (cfg_period == 16'd0 || nth_q >= cfg_period - 16'd1) ? 16'd0 : nth_q + 16'd1;
        burst_d = !(hdr_hs && cfg_mode == FAULT_MODE_BURST) ? burst_q :
                  (burst_q != 8'd0) ? burst_q - 8'd1 :
                  !rnd ? 8'd0 :
                  (cfg_burst_len == 8'd0) ? 8'd0 : cfg_burst_len - 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            nth_q   <= 16'd0;
            burst_q <= 8'd0;
        end else begin
            state_q <= state_d;
            nth_q   <= nth_d;
            burst_q <= burst_d;
        end
    end

    always_comb begin
        state_d = (state_q == ST_IDLE) ? (!hdr_hs ? ST_IDLE : drop ? ST_DROP : hit ? ST_MARK : ST_PASS) :
                  last_hs ? ST_IDLE : state_q;
    end

    // Payload is held off while IDLE so header and first beat never share a cycle
    always_comb begin
        fwd                   = state_q == ST_PASS || state_q == ST_MARK;
        s_hdr_ready           = !rst && state_q == ST_IDLE && (drop || m_hdr_ready);
        m_hdr_valid           = !rst && state_q == ST_IDLE && !drop && s_hdr_valid;
        m_hdr_data            = s_hdr_data;
        hdr_hs                = s_hdr_valid && s_hdr_ready;
        s_payload_axis_tready = !rst && (fwd ? m_payload_axis_tready : state_q == ST_DROP);
        m_payload_axis_tvalid = !rst && fwd && s_payload_axis_tvalid;
        m_payload_axis_tdata  = s_payload_axis_tdata;
        m_payload_axis_tkeep  = s_payload_axis_tkeep;
        m_payload_axis_tlast  = s_payload_axis_tlast;
        m_payload_axis_tuser  = s_payload_axis_tuser | (state_q == ST_MARK && s_payload_axis_tlast);
        last_hs               = s_payload_axis_tvalid && s_payload_axis_tready && s_payload_axis_tlast;
    end

`ifdef ROCE_FAULT_STATS_EN
    logic [CNT_WIDTH-1:0] frames_q, faults_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frames_q <= '0;
            faults_q <= '0;
        end else begin
            frames_q <= frames_q + CNT_WIDTH'(hdr_hs);
            faults_q <= faults_q + CNT_WIDTH'(hdr_hs && hit);
        end
    end

    assign stat_frames = frames_q;
    assign stat_faults = faults_q;
`else
    assign stat_frames = '0;
    assign stat_faults = '0;
`endif

endmodule
